score_lives_keeper: RTL and testbench
=====================================

// Module: score_lives_keeper
// PURPOSE
// - Consumes the per-frame collision pulses from the collision detector and owns game scoring and ball lives.
// - Accumulates events during a frame and commits them once per frame at startOfFrame.
// - Runs the game-state FSM and drives the score digits, lives count and ball freeze/respawn controls.
// - Outputs feed the score display and the ball mover.
// PARAMETERS
// - GOOD_PTS     default 10    points added for a good-obstacle hit in a frame
// - BAD_PTS      default 5     points subtracted for a bad-obstacle hit in a frame
// - BUMPER_PTS   default 25    points added for a bumper hit in a frame
// - INIT_LIVES   default 3     lives loaded at game start (1..7)
// - LOST_FRAMES  default 60    frames spent in BALL_LOST before respawn or game over (1..255)
// PORTS
// - clk                          in   1   system clock
// - reset                        in   1   synchronous, active-high reset
// - startOfFrame                 in   1   one-cycle pulse at frame start
// - startGame                    in   1   level; start/restart request (key press)
// - collisionSmileyObstacleGood  in   1   pulse, good-obstacle hit
// - collisionSmileyObstacleBad   in   1   pulse, bad-obstacle hit
// - collisionSmileyBumper        in   1   pulse, bumper hit
// - collisionSmileyBottom        in   1   level while ball pixel overlaps bottom
// - score                        out  14  binary score, 0..9999
// - scoreDigits                  out  16  BCD {thousands,hundreds,tens,units}
// - digitsValid                  out  1   scoreDigits match score
// - lives                        out  3   remaining lives
// - freezeBall                   out  1   1 = ball mover must hold ball
// - ballRespawn                  out  1   one-cycle pulse; reload ball start position
// - gameOver                     out  1   1 in GAME_OVER
// BEHAVIOUR
// - Reset state: state=IDLE, score=0, scoreDigits=0, digitsValid=1, lives=0, freezeBall=1, ballRespawn=0, gameOver=0.
//   All flags and counters are cleared.
// - Event flags:
//   - Four sticky flags: good, bad, bumper, bottom. Any assertion in the frame sets its flag.
//   - Each flag counts once per frame.
//   - Flags are only set in PLAY.
// - Commit on the startOfFrame cycle:
//   - The current flags are used for the commit.
//   - The flags are then loaded with that same cycle's inputs, so those events belong to the next frame.
// - Score arithmetic:
//   - new = score + good*GOOD_PTS + bumper*BUMPER_PTS - bad*BAD_PTS.
//   - Computed signed at 16 bits, then clamped to [0,9999]. No wrap in either direction.
//   - score updates on the cycle after the commit.
// - BCD conversion:
//   - A sequential double-dabble run starts on every score change. digitsValid=0 while it runs.
//   - scoreDigits is updated and digitsValid=1 exactly 15 cycles after the score update.
//   - A new change during a run restarts the run.
// - FSM:
//   - IDLE: freezeBall=1. On startGame=1: score=0, lives=INIT_LIVES, ballRespawn pulse, go to PLAY.
//   - PLAY: freezeBall=0. At a commit with the bottom flag set: score delta is still applied,
//     lives decrements, frame counter=0, go to BALL_LOST.
//   - BALL_LOST: freezeBall=1, frame counter increments on each startOfFrame.
//     - At count == LOST_FRAMES with lives > 0: ballRespawn pulse, go to PLAY.
//     - At count == LOST_FRAMES with lives == 0: go to GAME_OVER.
//   - GAME_OVER: gameOver=1, freezeBall=1, score is held. On startGame=1: same as the IDLE start action.
// - startGame is ignored in PLAY and BALL_LOST.
// - lives never underflows below 0.
// - ballRespawn is high for exactly one cycle per transition into PLAY.
// - reset mid-game: the next cycle matches the reset state, and any BCD run in progress is aborted.
// CONFIGURATION
// - EXTRA_LIFE_EN defined:
//   - Each commit whose new score crosses a multiple of 1000 (old/1000 != new/1000, increasing) adds 1 life, saturating at 7.
//   - The bonus is applied in the same cycle as the score update.
//   - A frame with bottom set applies the decrement after the bonus.
// - EXTRA_LIFE_EN undefined: lives only decrement; no score-based logic exists.
// TESTING
// - reset, startGame=1 -> PLAY, lives=3, score=0, one ballRespawn pulse, freezeBall=0.
// - good+bumper pulses in one frame, good pulsed 3x -> next commit score=35; scoreDigits=0x0035 after 15 cycles.
// - score=3, bad hit -> score=0 (clamp). score=9990 and bumper -> 9999.
// - bottom held 20 cycles -> lives 3->2 once, BALL_LOST, ballRespawn after 60 frames.
//   With lives=1 -> GAME_OVER, gameOver=1.
// - good pulse on the startOfFrame cycle -> not in this commit, counted in the next.
// - EXTRA_LIFE_EN: score 990 + bumper -> 1015, lives+1. Without the macro: lives unchanged.

Source files
------------

// File: rtl/score_lives_keeper_if.sv
// Frame/collision inputs and score, lives and ball-control outputs of score_lives_keeper.
interface score_lives_keeper_if;
  localparam int unsigned SCORE_W  = 14;
  localparam int unsigned DIGITS_W = 16;
  localparam int unsigned LIVES_W  = 3;

  logic                startOfFrame;
  logic                startGame;
  logic                collisionSmileyObstacleGood;
  logic                collisionSmileyObstacleBad;
  logic                collisionSmileyBumper;
  logic                collisionSmileyBottom;
  logic [SCORE_W-1:0]  score;
  logic [DIGITS_W-1:0] scoreDigits;
  logic                digitsValid;
  logic [LIVES_W-1:0]  lives;
  logic                freezeBall;
  logic                ballRespawn;
  logic                gameOver;

  modport master (
    output startOfFrame, startGame, collisionSmileyObstacleGood, collisionSmileyObstacleBad,
           collisionSmileyBumper, collisionSmileyBottom,
    input  score, scoreDigits, digitsValid, lives, freezeBall, ballRespawn, gameOver
  );

  modport slave (
    input  startOfFrame, startGame, collisionSmileyObstacleGood, collisionSmileyObstacleBad,
           collisionSmileyBumper, collisionSmileyBottom,
    output score, scoreDigits, digitsValid, lives, freezeBall, ballRespawn, gameOver
  );
endinterface

// File: rtl/score_lives_keeper.sv
// Per-frame score/lives bookkeeping, game-state FSM and sequential BCD conversion of the score.
// Optional feature: define EXTRA_LIFE_EN to award a life for every 1000-point boundary crossed.
module score_lives_keeper #(
  parameter int unsigned GOOD_PTS    = 10,
  parameter int unsigned BAD_PTS     = 5,
  parameter int unsigned BUMPER_PTS  = 25,
  parameter int unsigned INIT_LIVES  = 3,
  parameter int unsigned LOST_FRAMES = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  score_lives_keeper_if.slave  bus
);
  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned DIGITS_W  = 16;
  localparam int unsigned LIVES_W   = 3;
  localparam int unsigned FRAME_W   = 8;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned SUM_W     = 16;
  localparam int unsigned SCORE_MAX = 9999;
`ifdef EXTRA_LIFE_EN
  localparam int unsigned LIVES_MAX = 7;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, BALL_LOST, GAME_OVER} stateT;

  stateT                     state, stateNext;
  logic                      flagGood, flagBad, flagBumper, flagBottom;
  logic [FRAME_W-1:0]        frameCnt, frameCntNext;
  logic [SCORE_W-1:0]        scoreNext, scoreCommit;
  logic [LIVES_W-1:0]        livesNext;
  logic                      respawnNext;
  logic signed [SUM_W-1:0]   scoreSum;
  logic                      bcdBusy;
  logic [BIT_CNT_W-1:0]      bitCnt;
  logic [SCORE_W-1:0]        binShift;
  logic [DIGITS_W-1:0]       bcdShift, bcdAdj;

  // Score after applying this frame's flags, clamped to the displayable range
  always_comb begin
    scoreSum = signed'({2'b00, bus.score});
    if (flagGood)   scoreSum = scoreSum + signed'(SUM_W'(GOOD_PTS));
    if (flagBumper) scoreSum = scoreSum + signed'(SUM_W'(BUMPER_PTS));
    if (flagBad)    scoreSum = scoreSum - signed'(SUM_W'(BAD_PTS));
    if (scoreSum < signed'(SUM_W'(0)))
      scoreCommit = '0;
    else if (scoreSum > signed'(SUM_W'(SCORE_MAX)))
      scoreCommit = SCORE_W'(SCORE_MAX);
    else
      scoreCommit = SCORE_W'(scoreSum);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    scoreNext    = bus.score;
    livesNext    = bus.lives;
    frameCntNext = frameCnt;
    respawnNext  = 1'b0;
    case (state)
      IDLE, GAME_OVER: begin
        if (bus.startGame) begin
          stateNext   = PLAY;
          scoreNext   = '0;
          livesNext   = LIVES_W'(INIT_LIVES);
          respawnNext = 1'b1;
        end
      end
      PLAY: begin
        if (bus.startOfFrame) begin
          scoreNext = scoreCommit;
`ifdef EXTRA_LIFE_EN
          if ((scoreCommit / SCORE_W'(1000)) > (bus.score / SCORE_W'(1000)) &&
              livesNext != LIVES_W'(LIVES_MAX))
            livesNext = livesNext + LIVES_W'(1);
`endif
          if (flagBottom) begin
            if (livesNext != '0) livesNext = livesNext - LIVES_W'(1);
            frameCntNext = '0;
            stateNext    = BALL_LOST;
          end
        end
      end
      BALL_LOST: begin
        if (bus.startOfFrame) begin
          if (frameCnt == FRAME_W'(LOST_FRAMES - 1)) begin
            if (bus.lives != '0) begin
              stateNext   = PLAY;
              respawnNext = 1'b1;
            end else begin
              stateNext = GAME_OVER;
            end
          end else begin
            frameCntNext = frameCnt + FRAME_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Sticky per-frame event flags; the commit cycle's own inputs open the next frame
  always_ff @(posedge clk) begin
    if (reset || state != PLAY) begin
      flagGood   <= 1'b0;
      flagBad    <= 1'b0;
      flagBumper <= 1'b0;
      flagBottom <= 1'b0;
    end else if (bus.startOfFrame) begin
      flagGood   <= bus.collisionSmileyObstacleGood;
      flagBad    <= bus.collisionSmileyObstacleBad;
      flagBumper <= bus.collisionSmileyBumper;
      flagBottom <= bus.collisionSmileyBottom;
    end else begin
      flagGood   <= flagGood   | bus.collisionSmileyObstacleGood;
      flagBad    <= flagBad    | bus.collisionSmileyObstacleBad;
      flagBumper <= flagBumper | bus.collisionSmileyBumper;
      flagBottom <= flagBottom | bus.collisionSmileyBottom;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.score       <= '0;
      bus.lives       <= '0;
      frameCnt        <= '0;
      bus.freezeBall  <= 1'b1;
      bus.ballRespawn <= 1'b0;
      bus.gameOver    <= 1'b0;
    end else begin
      bus.score       <= scoreNext;
      bus.lives       <= livesNext;
      frameCnt        <= frameCntNext;
      bus.freezeBall  <= (stateNext != PLAY);
      bus.ballRespawn <= respawnNext;
      bus.gameOver    <= (stateNext == GAME_OVER);
    end
  end

  // Double-dabble add-3 correction applied before each shift
  always_comb begin
    bcdAdj = bcdShift;
    for (int d = 0; d < 4; d++) begin
      if (bcdShift[4*d +: 4] >= 4'd5) bcdAdj[4*d +: 4] = bcdShift[4*d +: 4] + 4'd3;
    end
  end

  // Load on score change, 14 shift cycles, then publish on the 15th cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      bcdBusy         <= 1'b0;
      bitCnt          <= '0;
      binShift        <= '0;
      bcdShift        <= '0;
      bus.scoreDigits <= '0;
      bus.digitsValid <= 1'b1;
    end else if (scoreNext != bus.score) begin
      bcdBusy         <= 1'b1;
      bitCnt          <= '0;
      binShift        <= scoreNext;
      bcdShift        <= '0;
      bus.digitsValid <= 1'b0;
    end else if (bcdBusy) begin
      if (bitCnt == BIT_CNT_W'(SCORE_W)) begin
        bus.scoreDigits <= bcdShift;
        bus.digitsValid <= 1'b1;
        bcdBusy         <= 1'b0;
      end else begin
        {bcdShift, binShift} <= {bcdAdj[DIGITS_W-2:0], binShift, 1'b0};
        bitCnt               <= bitCnt + BIT_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_score_lives_keeper.sv
// Directed self-checking bench for score_lives_keeper (honours EXTRA_LIFE_EN when defined).
module tb_score_lives_keeper;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   expScore;
  int   expLives;
  int   respawnCnt;

  always #5 clk = ~clk;

  score_lives_keeper_if bus ();
  score_lives_keeper dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampScore(input int s);
    return (s < 0) ? 0 : ((s > 9999) ? 9999 : s);
  endfunction

  // Advance one clock and sample 1 time unit after the edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.ballRespawn) respawnCnt++;
    end
  endtask

  task automatic sof();
    bus.startOfFrame = 1'b1;
    cyc(1);
    bus.startOfFrame = 1'b0;
  endtask

  task automatic pulse(input bit g, input bit b, input bit bu);
    bus.collisionSmileyObstacleGood = g;
    bus.collisionSmileyObstacleBad  = b;
    bus.collisionSmileyBumper       = bu;
    cyc(1);
    bus.collisionSmileyObstacleGood = 1'b0;
    bus.collisionSmileyObstacleBad  = 1'b0;
    bus.collisionSmileyBumper       = 1'b0;
    cyc(1);
  endtask

  // One frame of hits followed by its commit, checked against the score/lives model
  task automatic frame(input bit g, input bit b, input bit bu);
    int newScore;
    pulse(g, b, bu);
    sof();
    newScore = clampScore(expScore + (g ? 10 : 0) + (bu ? 25 : 0) - (b ? 5 : 0));
`ifdef EXTRA_LIFE_EN
    if (newScore / 1000 > expScore / 1000 && expLives < 7) expLives++;
`endif
    expScore = newScore;
    checkEq("frameScore", bus.score, expScore);
    checkEq("frameLives", bus.lives, expLives);
  endtask

  task automatic loseLife(input bit withGood);
    if (withGood) begin
      pulse(1'b1, 1'b0, 1'b0);
      expScore = clampScore(expScore + 10);
    end
    bus.collisionSmileyBottom = 1'b1;
    cyc(20);
    bus.collisionSmileyBottom = 1'b0;
    sof();
    if (expLives > 0) expLives--;
    checkEq("lostLives", bus.lives, expLives);
    checkEq("lostScore", bus.score, expScore);
    checkEq("lostFreeze", bus.freezeBall, 1);
    respawnCnt = 0;
    for (int f = 1; f < 60; f++) begin
      if (f == 2) bus.startGame = 1'b1;
      cyc(1);
      bus.startGame = 1'b0;
      sof();
    end
    checkEq("noEarlyRespawn", respawnCnt, 0);
    checkEq("stillFrozen", bus.freezeBall, 1);
    checkEq("livesHeldLost", bus.lives, expLives);
    cyc(1);
    sof();
    if (expLives > 0) begin
      checkEq("respawnPulse", bus.ballRespawn, 1);
      checkEq("respawnUnfreeze", bus.freezeBall, 0);
      cyc(1);
      checkEq("respawnOneCycle", bus.ballRespawn, 0);
      checkEq("respawnCount", respawnCnt, 1);
    end else begin
      checkEq("gameOverFlag", bus.gameOver, 1);
      checkEq("gameOverFreeze", bus.freezeBall, 1);
      checkEq("gameOverNoRespawn", respawnCnt, 0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkEq({tag, "Score"}, bus.score, 0);
    checkEq({tag, "Digits"}, bus.scoreDigits, 0);
    checkEq({tag, "Valid"}, bus.digitsValid, 1);
    checkEq({tag, "Lives"}, bus.lives, 0);
    checkEq({tag, "Freeze"}, bus.freezeBall, 1);
    checkEq({tag, "Respawn"}, bus.ballRespawn, 0);
    checkEq({tag, "GameOver"}, bus.gameOver, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.startOfFrame                = 1'b0;
    bus.startGame                   = 1'b0;
    bus.collisionSmileyObstacleGood = 1'b0;
    bus.collisionSmileyObstacleBad  = 1'b0;
    bus.collisionSmileyBumper       = 1'b0;
    bus.collisionSmileyBottom       = 1'b0;
    respawnCnt = 0;
    reset = 1'b1;
    cyc(2);
    checkResetState("reset");
    reset = 1'b0;
    cyc(2);
    checkEq("idleFreeze", bus.freezeBall, 1);

    // Start; startGame held into PLAY must not retrigger
    respawnCnt = 0;
    bus.startGame = 1'b1;
    cyc(1);
    checkEq("startRespawn", bus.ballRespawn, 1);
    checkEq("startLives", bus.lives, 3);
    checkEq("startFreeze", bus.freezeBall, 0);
    cyc(3);
    bus.startGame = 1'b0;
    cyc(1);
    checkEq("startRespawnOnce", respawnCnt, 1);
    checkEq("startScore", bus.score, 0);
    expScore = 0;
    expLives = 3;

    // good x3 + bumper in one frame -> 35, digits after 15 cycles
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    sof();
    checkEq("score35", bus.score, 35);
    checkEq("bcdBusy0", bus.digitsValid, 0);
    cyc(14);
    checkEq("bcdBusy14", bus.digitsValid, 0);
    cyc(1);
    checkEq("bcdValid15", bus.digitsValid, 1);
    checkEq("digits35", bus.scoreDigits, 32'h0035);

    // good on the commit cycle belongs to the next frame
    bus.collisionSmileyObstacleGood = 1'b1;
    bus.startOfFrame = 1'b1;
    cyc(1);
    bus.collisionSmileyObstacleGood = 1'b0;
    bus.startOfFrame = 1'b0;
    checkEq("sofGoodExcluded", bus.score, 35);
    cyc(1);
    sof();
    checkEq("sofGoodNext", bus.score, 45);

    // good + bad (bad twice) -> +5
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    sof();
    checkEq("goodBad", bus.score, 50);
    expScore = 50;
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    checkEq("clampLow", bus.score, 0);
    cyc(16);
    checkEq("digitsZero", bus.scoreDigits, 0);
    checkEq("digitsZeroValid", bus.digitsValid, 1);

    // Climb to 990, then bumper crosses 1000
    for (int i = 0; i < 28; i++) frame(1'b1, 1'b0, 1'b1);
    frame(1'b1, 1'b0, 1'b0);
    checkEq("score990", bus.score, 990);
    frame(1'b0, 1'b0, 1'b1);
    checkEq("score1015", bus.score, 1015);
`ifdef EXTRA_LIFE_EN
    checkEq("extraLife", bus.lives, 4);
`else
    checkEq("noExtraLife", bus.lives, 3);
`endif

    // Ball lost with a good hit in the same frame
    loseLife(1'b1);
    checkEq("lostFrameScore", bus.score, 1025);

    // Climb to 9990 then clamp high
    for (int i = 0; i < 256; i++) frame(1'b1, 1'b0, 1'b1);
    frame(1'b1, 1'b1, 1'b0);
    checkEq("score9990", bus.score, 9990);
    frame(1'b0, 1'b0, 1'b1);
    checkEq("clampHigh", bus.score, 9999);
    cyc(15);
    checkEq("digits9999", bus.scoreDigits, 32'h9999);
    checkEq("digits9999Valid", bus.digitsValid, 1);
    frame(1'b1, 1'b0, 1'b0);

    // Lose every remaining life -> GAME_OVER
    for (int i = 0; i < 8 && expLives > 0; i++) loseLife(1'b0);
    checkEq("gameOverScoreHeld", bus.score, 9999);
    checkEq("gameOverLives", bus.lives, 0);

    // Restart from GAME_OVER
    respawnCnt = 0;
    bus.startGame = 1'b1;
    cyc(1);
    bus.startGame = 1'b0;
    checkEq("restartGameOver", bus.gameOver, 0);
    checkEq("restartRespawn", bus.ballRespawn, 1);
    checkEq("restartLives", bus.lives, 3);
    checkEq("restartScore", bus.score, 0);
    checkEq("restartFreeze", bus.freezeBall, 0);
    expScore = 0;
    expLives = 3;
    cyc(16);
    checkEq("restartDigits", bus.scoreDigits, 0);

    // Reset during a BCD run
    frame(1'b1, 1'b0, 1'b0);
    cyc(5);
    reset = 1'b1;
    cyc(1);
    checkResetState("midReset");
    reset = 1'b0;
    cyc(20);
    checkEq("abortValid", bus.digitsValid, 1);
    checkEq("abortDigits", bus.scoreDigits, 0);
    checkEq("abortState", bus.freezeBall, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
